// File: rtl/prog_timer.sv
// prog_timer -- programmable tick timer with built-in prescaler.
//
// A prescaler divides clk into ticks (one every TICK_DIV enabled cycles while
// running). A CNT_W-bit counter advances once per tick, up from 0 to the
// latched limit or down from the limit to 0. Supports one-shot and
// auto-reload, level gating by enable, abort (stop) and retrigger (start).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   enable       level; prescaler/counter advance only while high in RUN
//   start        pulse; latches mode and limit, then (re)starts the timer
//   stop         pulse; aborts to IDLE (count held)
//   count_down   sampled at start: 1 = load_val->0, 0 = 0->load_val
//   auto_reload  sampled at start: 1 = periodic, 0 = one-shot
//   load_val     limit / period in ticks, sampled at start (0 = ignore start)
//   count        current count (registered)
//   tick         1-cycle pulse on each prescaler wrap in RUN
//   expired      1-cycle pulse when the terminal value is reached
//   busy         high while in RUN
//   done         high while in DONE (one-shot finished)
module prog_timer #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             count_down,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             expired,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] count_d;
  logic             tick_d, expired_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             dn_q, dn_d;
  logic             ar_q, ar_d;

  logic [CNT_W-1:0] nxt;
  logic             term;

  // Candidate count for the next tick. The terminal test fires exactly when
  // nxt reaches the end value, so the counter never wraps.
  assign nxt  = dn_q ? (count - CNT_W'(1)) : (count + CNT_W'(1));
  assign term = dn_q ? (nxt == '0) : (nxt == lim_q);

  // Next-state / next-output logic
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    count_d   = count;
    tick_d    = 1'b0;
    expired_d = 1'b0;
    lim_d     = lim_q;
    dn_d      = dn_q;
    ar_d      = ar_q;

    if (stop) begin
      // Abort wins over a coinciding wrap: no pulses, count kept.
      state_d = IDLE;
      presc_d = '0;
    end else if (start && (load_val != '0)) begin
      // Fresh start or retrigger: all progress is discarded.
      lim_d   = load_val;
      dn_d    = count_down;
      ar_d    = auto_reload;
      presc_d = '0;
      count_d = count_down ? load_val : '0;
      state_d = RUN;
    end else if ((state_q == RUN) && enable) begin
      if (presc_q != PRESC_MAX) begin
        presc_d = presc_q + DIV_W'(1);
      end else begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (!term) begin
          count_d = nxt;
        end else if (ar_q) begin
          expired_d = 1'b1;
          count_d   = dn_q ? lim_q : '0;
        end else begin
          expired_d = 1'b1;
          count_d   = nxt;
          state_d   = DONE;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      count   <= '0;
      tick    <= 1'b0;
      expired <= 1'b0;
      lim_q   <= '0;
      dn_q    <= 1'b0;
      ar_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count   <= count_d;
      tick    <= tick_d;
      expired <= expired_d;
      lim_q   <= lim_d;
      dn_q    <= dn_d;
      ar_q    <= ar_d;
    end
  end

  // Status flags come straight off the state flops.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
